// File: rtl/phasegen_n.sv
// Parametrised instruction-phase generator: one-hot phase rotation with run,
// single-phase, single-instruction and N-instruction stepping, stall and halt.
module phasegen_n #(
   parameter int unsigned NPHASE = 4,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              run,
   input  logic              step_phase,
   input  logic              step_inst,
   input  logic              step_n,
   input  logic [CNT_W-1:0]  n_inst,
   input  logic              stall,
   input  logic              halt,
   output logic [NPHASE-1:0] cstate,
   output logic              running,
   output logic              inst_done,
   output logic [CNT_W-1:0]  remaining
);

   typedef enum logic [2:0] {
      ST_STOP,
      ST_RUN,
      ST_STEP_INST,
      ST_STEP_PHASE,
      ST_STEP_N
   } state_t;

   state_t              state, state_nx;
   logic [NPHASE-1:0]   cstate_nx;
   logic                done_nx;
   logic [CNT_W-1:0]    remaining_nx;
   logic [NPHASE-1:0]   rotated;
   logic                last;

   assign rotated = {cstate[NPHASE-2:0], cstate[NPHASE-1]};
   assign last    = cstate[NPHASE-1];
   assign running = (state != ST_STOP);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= ST_STOP;
         cstate    <= NPHASE'(1);
         inst_done <= 1'b0;
         remaining <= '0;
      end else begin
         state     <= state_nx;
         cstate    <= cstate_nx;
         inst_done <= done_nx;
         remaining <= remaining_nx;
      end
   end

   // A run pulse stops any active mode without advancing; stall outranks halt.
   always_comb begin
      state_nx     = state;
      cstate_nx    = cstate;
      done_nx      = 1'b0;
      remaining_nx = remaining;
      unique case (state)
         ST_STOP: begin
            if (run)
               state_nx = ST_RUN;
            else if (step_inst)
               state_nx = ST_STEP_INST;
            else if (step_phase)
               state_nx = ST_STEP_PHASE;
            else if (step_n && (n_inst != '0)) begin
               state_nx     = ST_STEP_N;
               remaining_nx = n_inst;
            end
         end
         ST_RUN: begin
            if (run)
               state_nx = ST_STOP;
            else if (!stall) begin
               cstate_nx = rotated;
               if (last) begin
                  done_nx = 1'b1;
                  if (halt) state_nx = ST_STOP;
               end
            end
         end
         ST_STEP_INST: begin
            if (run)
               state_nx = ST_STOP;
            else if (!stall) begin
               cstate_nx = rotated;
               if (last) begin
                  done_nx  = 1'b1;
                  state_nx = ST_STOP;
               end
            end
         end
         ST_STEP_PHASE: begin
            if (run)
               state_nx = ST_STOP;
            else if (!stall) begin
               cstate_nx = rotated;
               done_nx   = last;
               state_nx  = ST_STOP;
            end
         end
         ST_STEP_N: begin
            if (run) begin
               state_nx     = ST_STOP;
               remaining_nx = '0;
            end else if (!stall) begin
               cstate_nx = rotated;
               if (last) begin
                  done_nx = 1'b1;
                  if ((remaining == CNT_W'(1)) || halt) begin
                     state_nx     = ST_STOP;
                     remaining_nx = '0;
                  end else begin
                     remaining_nx = remaining - CNT_W'(1);
                  end
               end
            end
         end
         default: state_nx = ST_STOP;
      endcase
   end

endmodule

// File: tb/tb_phasegen_n.sv
// Directed bench for phasegen_n: cycle-by-cycle vector table on a 4-phase
// instance, plus hand sequences for counting and a 6-phase async-reset case.
module tb_phasegen_n;

   logic       clock;
   logic       reset4, run4, sp4, si4, sn4, stall4, halt4;
   logic [7:0] n4;
   logic [3:0] cs4;
   logic       running4, done4;
   logic [7:0] rem4;

   logic       reset6, run6, sp6, si6, sn6, stall6, halt6;
   logic [7:0] n6;
   logic [5:0] cs6;
   logic       running6, done6;
   logic [7:0] rem6;

   int applied = 0;
   int miscompares = 0;

   phasegen_n #(.NPHASE(4), .CNT_W(8)) dut4 (
      .clock(clock), .reset(reset4), .run(run4), .step_phase(sp4),
      .step_inst(si4), .step_n(sn4), .n_inst(n4), .stall(stall4),
      .halt(halt4), .cstate(cs4), .running(running4), .inst_done(done4),
      .remaining(rem4));

   phasegen_n #(.NPHASE(6), .CNT_W(8)) dut6 (
      .clock(clock), .reset(reset6), .run(run6), .step_phase(sp6),
      .step_inst(si6), .step_n(sn6), .n_inst(n6), .stall(stall6),
      .halt(halt6), .cstate(cs6), .running(running6), .inst_done(done6),
      .remaining(rem6));

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic       r, sp, si, sn;
      logic [7:0] n;
      logic       st, h;
      logic [3:0] c;
      logic       ru, d;
      logic [7:0] rm;
   } vec_t;

   vec_t vt[$];

   task automatic add(input logic r, sp, si, sn, input int n, input logic st, h,
                      input logic [3:0] c, input logic ru, d, input int rm);
      vec_t v;
      v.r = r; v.sp = sp; v.si = si; v.sn = sn; v.n = n[7:0];
      v.st = st; v.h = h; v.c = c; v.ru = ru; v.d = d; v.rm = rm[7:0];
      vt.push_back(v);
   endtask

   task automatic chk(input string nm, input int idx, input int act, input int exp);
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s [%0d]: got %0h expected %0h", nm, idx, act, exp);
      end
   endtask

   task automatic chk4(input string nm, input int idx, input logic [3:0] c,
                       input logic ru, d, input logic [7:0] rm);
      applied++;
      chk({nm, ".cstate"}, idx, int'(cs4), int'(c));
      chk({nm, ".running"}, idx, int'(running4), int'(ru));
      chk({nm, ".inst_done"}, idx, int'(done4), int'(d));
      chk({nm, ".remaining"}, idx, int'(rem4), int'(rm));
   endtask

   task automatic chk6(input string nm, input logic [5:0] c, input logic ru, d,
                       input logic [7:0] rm);
      applied++;
      chk({nm, ".cstate"}, 0, int'(cs6), int'(c));
      chk({nm, ".running"}, 0, int'(running6), int'(ru));
      chk({nm, ".inst_done"}, 0, int'(done6), int'(d));
      chk({nm, ".remaining"}, 0, int'(rem6), int'(rm));
   endtask

   task automatic tick6();
      @(posedge clock);
      #1;
      run6 = 1'b0; sp6 = 1'b0; si6 = 1'b0; sn6 = 1'b0;
   endtask

   int cnt_run, cnt_done;
   bit ended;

   initial begin
      {run4, sp4, si4, sn4, stall4, halt4} = '0; n4 = '0;
      {run6, sp6, si6, sn6, stall6, halt6} = '0; n6 = '0;
      reset4 = 1'b0; reset6 = 1'b0;

      //   r sp si sn  n st h  cstate  ru d rm
      add(0,0,0,0, 0,0,0,4'b0001,0,0,0);  // idle in STOP
      add(1,0,0,0, 0,0,0,4'b0001,1,0,0);  // run accepted, no advance
      add(0,0,0,0, 0,0,0,4'b0010,1,0,0);
      add(0,0,0,0, 0,0,0,4'b0100,1,0,0);
      add(0,0,0,0, 0,0,0,4'b1000,1,0,0);
      add(0,0,0,0, 0,0,0,4'b0001,1,1,0);
      add(0,0,0,0, 0,0,0,4'b0010,1,0,0);
      add(0,0,0,0, 0,0,0,4'b0100,1,0,0);
      add(1,0,0,0, 0,0,0,4'b0100,0,0,0);  // run stops mid-instruction
      add(0,0,0,0, 0,0,0,4'b0100,0,0,0);
      add(0,0,1,0, 0,0,0,4'b0100,1,0,0);  // step_inst entered mid-instruction
      add(0,0,0,0, 0,0,0,4'b1000,1,0,0);
      add(0,0,0,0, 0,0,0,4'b0001,0,1,0);
      add(0,0,0,0, 0,0,0,4'b0001,0,0,0);
      add(0,0,1,0, 0,0,0,4'b0001,1,0,0);  // step_inst from phase 0
      add(0,0,0,0, 0,0,0,4'b0010,1,0,0);
      add(0,0,0,0, 0,0,0,4'b0100,1,0,0);
      add(0,0,0,0, 0,0,0,4'b1000,1,0,0);
      add(0,0,0,0, 0,0,0,4'b0001,0,1,0);
      add(0,0,0,0, 0,0,0,4'b0001,0,0,0);
      add(0,1,0,0, 0,0,0,4'b0001,1,0,0);  // step_phase x3
      add(0,0,0,0, 0,0,0,4'b0010,0,0,0);
      add(0,1,0,0, 0,0,0,4'b0010,1,0,0);
      add(0,0,0,0, 0,0,0,4'b0100,0,0,0);
      add(0,1,0,0, 0,0,0,4'b0100,1,0,0);
      add(0,0,0,0, 0,0,0,4'b1000,0,0,0);
      add(0,1,0,0, 0,0,0,4'b1000,1,0,0);  // step_phase out of last phase
      add(0,0,0,0, 0,0,0,4'b0001,0,1,0);
      add(0,0,0,0, 0,0,0,4'b0001,0,0,0);
      add(1,0,1,0, 0,0,0,4'b0001,1,0,0);  // run beats step_inst
      add(0,0,0,0, 0,0,0,4'b0010,1,0,0);
      add(0,0,0,0, 0,0,0,4'b0100,1,0,0);
      add(0,0,0,0, 0,0,0,4'b1000,1,0,0);
      add(0,0,0,0, 0,0,0,4'b0001,1,1,0);  // still running: RUN chosen
      add(1,0,0,0, 0,0,0,4'b0001,0,0,0);
      add(0,0,0,1, 0,0,0,4'b0001,0,0,0);  // step_n with zero ignored
      add(0,1,1,0, 0,0,0,4'b0001,1,0,0);  // step_inst beats step_phase
      add(0,0,0,0, 0,0,0,4'b0010,1,0,0);
      add(0,0,0,0, 0,0,0,4'b0100,1,0,0);
      add(0,0,0,0, 0,0,0,4'b1000,1,0,0);
      add(0,0,0,0, 0,0,0,4'b0001,0,1,0);
      add(1,0,0,0, 0,0,0,4'b0001,1,0,0);  // stall 5 cycles in phase 2
      add(0,0,0,0, 0,0,0,4'b0010,1,0,0);
      add(0,0,0,0, 0,0,0,4'b0100,1,0,0);
      add(0,0,0,0, 0,1,0,4'b0100,1,0,0);
      add(0,0,0,0, 0,1,0,4'b0100,1,0,0);
      add(0,0,0,0, 0,1,0,4'b0100,1,0,0);
      add(0,0,0,0, 0,1,0,4'b0100,1,0,0);
      add(0,0,0,0, 0,1,0,4'b0100,1,0,0);
      add(0,0,0,0, 0,0,0,4'b1000,1,0,0);
      add(0,0,0,0, 0,0,0,4'b0001,1,1,0);
      add(0,0,0,0, 0,0,0,4'b0010,1,0,0);
      add(0,0,0,0, 0,0,0,4'b0100,1,0,0);
      add(0,0,0,0, 0,0,0,4'b1000,1,0,0);
      add(0,0,0,0, 0,1,0,4'b1000,1,0,0);  // stall at last phase
      add(0,0,0,0, 0,0,0,4'b0001,1,1,0);
      add(0,0,0,0, 0,0,1,4'b0010,1,0,0);  // halt early, released: no effect
      add(0,0,0,0, 0,0,1,4'b0100,1,0,0);
      add(0,0,0,0, 0,0,0,4'b1000,1,0,0);
      add(0,0,0,0, 0,0,0,4'b0001,1,1,0);
      add(0,0,0,0, 0,0,1,4'b0010,1,0,0);  // halt held in RUN
      add(0,0,0,0, 0,0,1,4'b0100,1,0,0);
      add(0,0,0,0, 0,0,1,4'b1000,1,0,0);
      add(0,0,0,0, 0,0,1,4'b0001,0,1,0);
      add(1,0,0,0, 0,0,0,4'b0001,1,0,0);
      add(0,0,0,0, 0,0,0,4'b0010,1,0,0);
      add(0,0,0,0, 0,0,0,4'b0100,1,0,0);
      add(0,0,0,0, 0,0,0,4'b1000,1,0,0);
      add(0,0,0,0, 0,1,1,4'b1000,1,0,0);  // stall+halt at last: stay
      add(0,0,0,0, 0,0,1,4'b0001,0,1,0);
      add(0,0,0,0, 0,0,0,4'b0001,0,0,0);
      add(0,0,0,1, 3,0,0,4'b0001,1,0,3);  // step_n 3
      add(0,0,0,0, 0,0,0,4'b0010,1,0,3);
      add(0,0,0,0, 0,0,0,4'b0100,1,0,3);
      add(0,0,0,0, 0,0,0,4'b1000,1,0,3);
      add(0,0,0,0, 0,0,0,4'b0001,1,1,2);
      add(0,0,0,0, 0,0,0,4'b0010,1,0,2);
      add(0,0,0,0, 0,0,0,4'b0100,1,0,2);
      add(0,0,0,0, 0,0,0,4'b1000,1,0,2);
      add(0,0,0,0, 0,0,0,4'b0001,1,1,1);
      add(0,0,0,0, 0,0,0,4'b0010,1,0,1);
      add(0,0,0,0, 0,0,0,4'b0100,1,0,1);
      add(0,0,0,0, 0,0,0,4'b1000,1,0,1);
      add(0,0,0,0, 0,0,0,4'b0001,0,1,0);
      add(0,0,0,0, 0,0,0,4'b0001,0,0,0);
      add(0,0,0,1,10,0,0,4'b0001,1,0,10); // step_n 10 with halt
      add(0,0,0,0, 0,0,1,4'b0010,1,0,10);
      add(0,0,0,0, 0,0,1,4'b0100,1,0,10);
      add(0,0,0,0, 0,0,1,4'b1000,1,0,10);
      add(0,0,0,0, 0,0,1,4'b0001,0,1,0);
      add(0,0,0,1, 5,0,0,4'b0001,1,0,5);  // run aborts step_n
      add(0,0,0,0, 0,0,0,4'b0010,1,0,5);
      add(1,0,0,0, 0,0,0,4'b0010,0,0,0);
      add(0,1,0,1, 4,0,0,4'b0010,1,0,0);  // step_phase beats step_n
      add(0,0,0,0, 0,0,0,4'b0100,0,0,0);
      add(0,0,1,0, 0,0,0,4'b0100,1,0,0);
      add(0,0,0,0, 0,0,0,4'b1000,1,0,0);
      add(0,0,0,0, 0,0,0,4'b0001,0,1,0);
      add(0,0,0,0, 0,0,0,4'b0001,0,0,0);

      #12;
      chk4("reset", 0, 4'b0001, 1'b0, 1'b0, 8'd0);
      chk6("reset6", 6'b000001, 1'b0, 1'b0, 8'd0);
      @(negedge clock);
      reset4 = 1'b1; reset6 = 1'b1;
      @(posedge clock);
      #1;

      foreach (vt[i]) begin
         run4 = vt[i].r; sp4 = vt[i].sp; si4 = vt[i].si; sn4 = vt[i].sn;
         n4 = vt[i].n; stall4 = vt[i].st; halt4 = vt[i].h;
         @(posedge clock);
         #1;
         chk4("vec", i, vt[i].c, vt[i].ru, vt[i].d, vt[i].rm);
      end
      {run4, sp4, si4, sn4, stall4, halt4} = '0; n4 = '0;

      // step_n 2 from phase 0: running for 2*4 cycles plus the accept cycle
      sn4 = 1'b1; n4 = 8'd2;
      cnt_run = 1; cnt_done = 0; ended = 1'b0;
      for (int k = 0; k < 40 && !ended; k++) begin
         @(posedge clock);
         #1;
         sn4 = 1'b0; n4 = '0;
         if (running4) cnt_run++;
         if (done4) cnt_done++;
         if (!running4) ended = 1'b1;
      end
      applied++;
      chk("stepn2.ended", 0, int'(ended), 1);
      chk("stepn2.run_cycles", 0, cnt_run, 9);
      chk("stepn2.done_pulses", 0, cnt_done, 2);
      chk("stepn2.cstate", 0, int'(cs4), 1);

      // 6-phase instance: rotation, then async reset mid step_n
      run6 = 1'b1;
      tick6();
      chk6("run6.accept", 6'b000001, 1'b1, 1'b0, 8'd0);
      for (int k = 1; k <= 7; k++) begin
         tick6();
         chk6("run6.rot", 6'(1 << (k % 6)), 1'b1, (k == 6), 8'd0);
      end
      run6 = 1'b1;
      tick6();
      chk6("run6.stop", 6'b000010, 1'b0, 1'b0, 8'd0);
      sn6 = 1'b1; n6 = 8'd2;
      tick6();
      n6 = '0;
      chk6("stepn6.accept", 6'b000010, 1'b1, 1'b0, 8'd2);
      tick6();
      tick6();
      chk6("stepn6.phase3", 6'b001000, 1'b1, 1'b0, 8'd2);
      #2;
      reset6 = 1'b0;
      #1;
      chk6("reset6.async", 6'b000001, 1'b0, 1'b0, 8'd0);
      @(negedge clock);
      reset6 = 1'b1;
      tick6();
      chk6("reset6.after", 6'b000001, 1'b0, 1'b0, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
